cdb_arbiter: RTL and testbench

- Sits directly upstream of the CDB driver, between the functional-unit completion outputs and the single-wide common data bus.
- Accepts completed results from NUM_FU execution units and buffers each in a per-unit FIFO.
- Grants one result per cycle using round-robin priority and presents it from a registered output stage.
- Applies backpressure to stalled units and drops all buffered results on a mispredict squash.

---
 rtl/cdb_arbiter_if.sv | 60 ++++++
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 tb/tb_cdb_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// CDB arbiter packet types and source/broadcast bundle.
// Sources and CDB driver attach through the master side.
package cdb_pkg;

  typedef struct packed {
    logic [31:0] PC;
    logic [31:0] alu_result;
    logic [4:0]  dest_reg_idx;
    logic        take_branch;
    logic        halt;
  } EX_PACKET;

endpackage

interface cdb_arbiter_if #(
  parameter int NUM_FU = 4
);
  import cdb_pkg::*;

  localparam int SW = $clog2(NUM_FU);

  logic     [NUM_FU-1:0] fu_valid;
  EX_PACKET [NUM_FU-1:0] fu_packet;
  logic     [NUM_FU-1:0] fu_correct_predict;
  logic     [NUM_FU-1:0] fu_no_output;
  logic     [NUM_FU-1:0] fu_ready;

  logic                  out_valid;
  EX_PACKET              out_packet;
  logic                  out_correct_predict;
  logic                  out_no_output;
  logic     [SW-1:0]     out_src;

  modport master (
    output fu_valid,
    output fu_packet,
    output fu_correct_predict,
    output fu_no_output,
    input  fu_ready,
    input  out_valid,
    input  out_packet,
    input  out_correct_predict,
    input  out_no_output,
    input  out_src
  );

  modport slave (
    input  fu_valid,
    input  fu_packet,
    input  fu_correct_predict,
    input  fu_no_output,
    output fu_ready,
    output out_valid,
    output out_packet,
    output out_correct_predict,
    output out_no_output,
    output out_src
  );

endinterface

// File: rtl/cdb_arbiter.sv
// Per-source completion FIFOs with round-robin grant
// onto a registered single-wide CDB output stage.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int DEPTH  = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         squash,
  cdb_arbiter_if.slave bus
);

  localparam int SW = $clog2(NUM_FU);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    EX_PACKET pkt;
    logic     cp;
    logic     no;
  } entry_t;

  entry_t      mem    [NUM_FU][DEPTH];
  logic [CW-1:0] cnt    [NUM_FU];
  logic [PW-1:0] wr_ptr [NUM_FU];
  logic [PW-1:0] rd_ptr [NUM_FU];
  logic [SW-1:0] rr_ptr;

  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] enq;
  logic [NUM_FU-1:0] deq;
  logic              gnt_vld;
  logic [SW-1:0]     gnt;
  logic [SW-1:0]     idx;

  always_comb begin
    ready = '0;
    enq   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      ready[i] = (cnt[i] != CW'(DEPTH));
      enq[i]   = bus.fu_valid[i] && ready[i]
                 && !squash;
    end
  end

  assign bus.fu_ready = ready;

  // Only registered counts are candidates; no bypass.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    deq     = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = rr_ptr + SW'(k);
      if (!gnt_vld && cnt[idx] != '0) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
    for (int i = 0; i < NUM_FU; i++) begin
      deq[i] = gnt_vld && (gnt == SW'(i));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        cnt[i]    <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          mem[i][d] <= '0;
        end
      end
      rr_ptr                  <= '0;
      bus.out_valid           <= 1'b0;
      bus.out_packet          <= '0;
      bus.out_correct_predict <= 1'b0;
      bus.out_no_output       <= 1'b0;
      bus.out_src             <= '0;
    end else if (squash) begin
      // Output fields and rr_ptr hold across a flush.
      for (int i = 0; i < NUM_FU; i++) begin
        cnt[i]    <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      bus.out_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (enq[i]) begin
          mem[i][wr_ptr[i]] <= '{
            pkt: bus.fu_packet[i],
            cp:  bus.fu_correct_predict[i],
            no:  bus.fu_no_output[i]
          };
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (deq[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        cnt[i] <= cnt[i] + CW'(enq[i])
                  - CW'(deq[i]);
      end
      if (gnt_vld) begin
        bus.out_valid           <= 1'b1;
        bus.out_packet          <= mem[gnt][rd_ptr[gnt]].pkt;
        bus.out_correct_predict <= mem[gnt][rd_ptr[gnt]].cp;
        bus.out_no_output       <= mem[gnt][rd_ptr[gnt]].no;
        bus.out_src             <= gnt;
        rr_ptr                  <= gnt + 1'b1;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: ordering, latency,
// backpressure, squash, async reset and FIFO wrap.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  typedef struct {
    logic [1:0] src;
    EX_PACKET   pkt;
    logic       cp;
    logic       no;
  } exp_t;

  logic clock;
  logic reset;
  logic squash;
  int   errors;
  int   checks;
  exp_t q[$];

  cdb_arbiter_if #(.NUM_FU(4)) bus ();

  cdb_arbiter #(
    .NUM_FU (4),
    .DEPTH  (2)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic EX_PACKET mk(input int s, input int n);
    EX_PACKET p;
    p              = '0;
    p.PC           = 32'(n * 4);
    p.alu_result   = 32'(32'hA000 + s * 256 + n);
    p.dest_reg_idx = 5'(n + s);
    p.take_branch  = (n % 3) == 0;
    return p;
  endfunction

  function automatic logic mk_cp(input int n);
    return (n % 2) == 1;
  endfunction

  function automatic logic mk_no(input int s);
    return (s % 2) == 1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input int n);
    for (int s = 0; s < 4; s++) begin
      bus.fu_packet[s]          = mk(s, n);
      bus.fu_correct_predict[s] = mk_cp(n);
      bus.fu_no_output[s]       = mk_no(s);
    end
    bus.fu_valid = v;
  endtask

  task automatic push(input int s, input int n);
    exp_t e;
    e.src = 2'(s);
    e.pkt = mk(s, n);
    e.cp  = mk_cp(n);
    e.no  = mk_no(s);
    q.push_back(e);
  endtask

  // Scoreboard: every broadcast must match the next expected.
  always @(negedge clock) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected src=%0d pc=%h",
                 bus.out_src, bus.out_packet.PC);
      end else begin
        e = q.pop_front();
        if (bus.out_src !== e.src ||
            bus.out_packet !== e.pkt ||
            bus.out_correct_predict !== e.cp ||
            bus.out_no_output !== e.no) begin
          errors++;
          $display("FAIL sb_data got src=%0d pkt=%h cp=%b no=%b want src=%0d pkt=%h cp=%b no=%b",
                   bus.out_src, bus.out_packet,
                   bus.out_correct_predict, bus.out_no_output,
                   e.src, e.pkt, e.cp, e.no);
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clock);
    #1;
    reset        = 1'b0;
    squash       = 1'b0;
    bus.fu_valid = '0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_src !== 2'd0 ||
        bus.out_packet !== '0 ||
        bus.out_correct_predict !== 1'b0 ||
        bus.out_no_output !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got v=%b src=%0d pkt=%h want 0",
               bus.out_valid, bus.out_src, bus.out_packet);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if (bus.fu_ready !== 4'hF) begin
      errors++;
      $display("FAIL reset_ready got %b want 1111",
               bus.fu_ready);
    end
  endtask

  task automatic test_single();
    exp_t e;
    e.src              = 2'd2;
    e.pkt              = '0;
    e.pkt.dest_reg_idx = 5'd5;
    e.pkt.alu_result   = 32'h1234;
    e.cp               = 1'b1;
    e.no               = 1'b0;
    q.push_back(e);
    bus.fu_packet[2]          = e.pkt;
    bus.fu_correct_predict[2] = 1'b1;
    bus.fu_no_output[2]       = 1'b0;
    bus.fu_valid              = 4'b0100;
    step();
    bus.fu_valid = '0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early got v=%b want 0",
               bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd2 ||
        bus.out_packet.alu_result !== 32'h1234) begin
      errors++;
      $display("FAIL single_lat got v=%b src=%0d alu=%h want 1 2 1234",
               bus.out_valid, bus.out_src,
               bus.out_packet.alu_result);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_after got v=%b want 0",
               bus.out_valid);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    drive(4'b1111, 1);
    for (int s = 0; s < 4; s++) push(s, 1);
    step();
    bus.fu_valid = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_src !== 2'(i)) begin
        errors++;
        $display("FAIL rr_order got v=%b src=%0d want 1 %0d",
                 bus.out_valid, bus.out_src, i);
      end
    end
    drive(4'b0011, 2);
    push(0, 2);
    push(1, 2);
    step();
    bus.fu_valid = '0;
    step();
    checks++;
    if (bus.out_src !== 2'd0) begin
      errors++;
      $display("FAIL rr_wrap got src=%0d want 0", bus.out_src);
    end
    step();
    checks++;
    if (bus.out_src !== 2'd1) begin
      errors++;
      $display("FAIL rr_next got src=%0d want 1", bus.out_src);
    end
    step();
  endtask

  task automatic test_backpressure();
    apply_reset();
    drive(4'b0010, 0);
    push(1, 0);
    step();
    bus.fu_valid = '0;
    step();
    step();
    step();
    // rr_ptr now 2: search order is 2,3,0,1.
    drive(4'b1101, 1);
    push(2, 1);
    push(3, 1);
    push(0, 1);
    push(1, 1);
    push(1, 2);
    step();
    drive(4'b0010, 1);
    step();
    drive(4'b0010, 2);
    step();
    checks++;
    if (bus.fu_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got %b want 0", bus.fu_ready[1]);
    end
    drive(4'b0010, 99);
    step();
    bus.fu_valid = '0;
    checks++;
    if (bus.fu_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got %b want 0", bus.fu_ready[1]);
    end
    step();
    checks++;
    if (bus.fu_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_free got %b want 1", bus.fu_ready[1]);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain got %0d left want 0", q.size());
    end
  endtask

  task automatic test_squash();
    logic bad;
    apply_reset();
    drive(4'b0111, 5);
    push(0, 5);
    step();
    bus.fu_valid = '0;
    step();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL sq_inflight got v=%b want 1",
               bus.out_valid);
    end
    squash = 1'b1;
    drive(4'b1000, 6);
    step();
    squash       = 1'b0;
    bus.fu_valid = '0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.fu_ready !== 4'hF) begin
      errors++;
      $display("FAIL sq_flush got v=%b rdy=%b want 0 1111",
               bus.out_valid, bus.fu_ready);
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL sq_quiet got stray grant want none");
    end
    // rr_ptr survives the flush: source 1 now beats source 0.
    drive(4'b0011, 3);
    push(1, 3);
    push(0, 3);
    step();
    bus.fu_valid = '0;
    step();
    checks++;
    if (bus.out_src !== 2'd1) begin
      errors++;
      $display("FAIL sq_rr got src=%0d want 1", bus.out_src);
    end
    step();
    step();
  endtask

  task automatic test_async_reset();
    logic bad;
    drive(4'b1111, 7);
    step();
    bus.fu_valid = '0;
    step();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre got v=%b want 1", bus.out_valid);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_async got v=%b want 0",
               bus.out_valid);
    end
    @(negedge clock);
    #2;
    reset = 1'b1;
    step();
    checks++;
    if (bus.fu_ready !== 4'hF) begin
      errors++;
      $display("FAIL ar_ready got %b want 1111", bus.fu_ready);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL ar_stale got stale grant want none");
    end
  endtask

  task automatic test_back_to_back();
    logic bad;
    bad = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (bus.fu_ready[3] !== 1'b1) bad = 1'b1;
      if (n >= 2 && bus.out_valid !== 1'b1) bad = 1'b1;
      drive(4'b1000, n);
      push(3, n);
      step();
    end
    bus.fu_valid = '0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL b2b_stream got gap or stall want none");
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 ||
        bus.out_packet.PC !== 32'd28) begin
      errors++;
      $display("FAIL b2b_last got v=%b pc=%0d want 1 28",
               bus.out_valid, bus.out_packet.PC);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_end got v=%b left=%0d want 0 0",
               bus.out_valid, q.size());
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b0;
    squash       = 1'b0;
    bus.fu_valid = '0;
    drive(4'b0000, 0);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_squash();
    test_async_reset();
    test_back_to_back();
    step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
